bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Registered round-robin arbiter for the shared two-CPU coherence bus.
- Accepts bus requests from cpu0 and cpu1 and grants exactly one owner at a time.
- Latches the owner's bus opcode and holds ownership until the owner signals done or a hold timeout fires.
- Sits between the per-CPU cache controllers and the bus coherence FSM; the `grant_x`/`bus_op` outputs feed that FSM's request inputs.

Parameters:
- OPW, 3, width of bus opcode (matches the bus_op_t encoding; 0 = NOOP).
- MAX_HOLD, 8, maximum cycles an owner may hold the bus before forced release (legal range 2..255).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req_0  input  1  cpu0 bus request; level, held until granted.
- req_1  input  1  cpu1 bus request; level, held until granted.
- op_0  input  OPW  cpu0 requested opcode; valid while req_0=1.
- op_1  input  OPW  cpu1 requested opcode; valid while req_1=1.
- done_0  input  1  cpu0 ends its transaction; single-cycle pulse; ignored unless cpu0 owns the bus.
- done_1  input  1  cpu1 ends its transaction; as done_0.
- grant_0  output  1  cpu0 owns the bus.
- grant_1  output  1  cpu1 owns the bus.
- owner  output  1  0 = cpu0, 1 = cpu1; meaningful only while bus_valid=1.
- bus_valid  output  1  a transaction is active.
- bus_op  output  OPW  latched opcode of the current owner; 0 when bus_valid=0.
- timeout_err  output  1  one-cycle pulse on forced release.
- xact_cnt_0  output  16  cpu0 completed-grant count (see Optional Feature).
- xact_cnt_1  output  16  cpu1 completed-grant count.

Behaviour:
- Every output is registered.
- Reset (rst=1 at a posedge):
  - state=IDLE, all outputs 0, priority pointer=cpu0, hold counter=0.
  - Applies from any state, including mid-grant; the aborted grant is not counted.
- State IDLE:
  - No request: stay IDLE.
  - One request: go to GRANT for that requester.
  - Both requests: grant the CPU the priority pointer selects.
  - Grant latency: req sampled at edge N gives grant_x=1, bus_valid=1 and bus_op=op_x latched, all visible after edge N.
- State GRANT:
  - grant_x, owner, bus_valid and bus_op are held constant.
  - The op_x input is not re-sampled.
  - Hold counter increments each cycle in GRANT, starting at 0 on entry.
- Exit to RELEASE on whichever comes first:
  - done_x from the owner; done from the non-owner is ignored.
  - The owner drops req_x: abandon; treated as done but not counted.
  - Hold counter == MAX_HOLD-1 with no done: forced release; timeout_err=1 for exactly one cycle, coincident with the RELEASE cycle.
  - If done arrives in the same cycle the counter hits MAX_HOLD-1, done wins and there is no timeout.
- State RELEASE:
  - Exactly one turnaround cycle with all grants 0, bus_valid=0, bus_op=0.
  - Priority pointer moves to the other CPU.
  - Next state is IDLE. A request pending during RELEASE is granted after the IDLE evaluation, so the minimum gap between grants is 2 dead cycles.
- Invariants:
  - grant_0 & grant_1 is never 1.
  - bus_valid == grant_0 | grant_1.
- Fairness: under continuous requests from both CPUs, grants strictly alternate 0,1,0,1...
- Hold counter is 8 bits; it never wraps because it is reset on entry to GRANT.

Optional Feature:
- Macro: BUS_ARB_STATS_EN.
- Defined:
  - xact_cnt_0/xact_cnt_1 increment by 1 on each done-terminated grant of that CPU (edge entering RELEASE).
  - Counters saturate at 16'hFFFF.
  - Timeouts and abandons do not count.
  - Counters reset to 0 on rst.
- Undefined: xact_cnt_0/xact_cnt_1 are tied to 16'h0000 and no counter flops are inferred.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then release with no requests for 10 cycles -> all outputs 0, grant_0=grant_1=0 throughout.
- Single request: req_0=1, op_0=3'd1 at cycle 0; done_0 pulse at cycle 3 -> grant_0=1, bus_op=1 during cycles 1..3; cycle 4 RELEASE with all outputs 0; xact_cnt_0=1 (stats on).
- Contention/round-robin: req_0=req_1=1 held continuously, done pulsed 2 cycles after each grant -> grant order 0,1,0,1; never both high; bus_op tracks op_0/op_1.
- Timeout: MAX_HOLD=8, req_1=1, no done -> grant_1 high for 8 cycles, then timeout_err=1 for exactly 1 cycle; grant_1=0; xact_cnt_1 unchanged.
- Done/timeout tie plus foreign done: done_1 pulsed on the 8th grant cycle -> no timeout_err, xact_cnt_1 +1; done_0 pulsed while cpu1 owns -> no effect.
- Reset mid-grant: rst=1 during cycle 2 of a cpu1 grant -> next cycle all outputs 0, priority back to cpu0; with both requesting afterwards, cpu0 is granted first.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: groups the two CPU request/opcode/done channels
// and the arbiter's grant, opcode and statistics outputs.
// The cache-controller side uses the master modport, the arbiter uses slave.
interface bus_arbiter_if #(
    parameter int OPW = 3
);
    logic           req_0;
    logic           req_1;
    logic [OPW-1:0] op_0;
    logic [OPW-1:0] op_1;
    logic           done_0;
    logic           done_1;
    logic           grant_0;
    logic           grant_1;
    logic           owner;
    logic           bus_valid;
    logic [OPW-1:0] bus_op;
    logic           timeout_err;
    logic [15:0]    xact_cnt_0;
    logic [15:0]    xact_cnt_1;

    modport master (
        output req_0, req_1, op_0, op_1, done_0, done_1,
        input  grant_0, grant_1, owner, bus_valid, bus_op, timeout_err,
        input  xact_cnt_0, xact_cnt_1
    );

    modport slave (
        input  req_0, req_1, op_0, op_1, done_0, done_1,
        output grant_0, grant_1, owner, bus_valid, bus_op, timeout_err,
        output xact_cnt_0, xact_cnt_1
    );
endinterface

// File: rtl/bus_arbiter.sv
// Registered round-robin arbiter for the shared two-CPU coherence bus.
// One owner at a time; the owner's opcode is latched at grant and held
// until the owner signals done, drops its request, or the hold timeout fires.
// Every grant is followed by one RELEASE turnaround cycle and one IDLE
// evaluation cycle, after which the priority pointer favours the other CPU.
// Optional feature: define BUS_ARB_STATS_EN to enable the per-CPU
// completed-grant counters; otherwise xact_cnt_0/xact_cnt_1 read zero.
module bus_arbiter #(
    parameter int OPW      = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Last hold-counter value an owner may reach before being forced off.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t         state_q;
    state_t         state_d;
    logic           own_q;
    logic           own_d;
    logic [OPW-1:0] op_q;
    logic [OPW-1:0] op_d;
    logic [7:0]     hold_q;
    logic [7:0]     hold_d;
    logic           prio_q;
    logic           prio_d;
    logic           tout_q;
    logic           tout_d;
    logic           grant_0_q;
    logic           grant_1_q;
    logic           valid_q;
    logic           owner_done;
    logic           owner_req;

    // Next-state logic: picks a winner in IDLE, watches done/abandon/timeout
    // in GRANT, and forces a single dead cycle in RELEASE.
    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        op_d       = op_q;
        hold_d     = hold_q;
        prio_d     = prio_q;
        tout_d     = 1'b0;
        owner_done = own_q ? bus.done_1 : bus.done_0;
        owner_req  = own_q ? bus.req_1  : bus.req_0;

        case (state_q)
            IDLE: begin
                if (bus.req_0 && (!bus.req_1 || !prio_q)) begin
                    state_d = GRANT;
                    own_d   = 1'b0;
                    op_d    = bus.op_0;
                    hold_d  = 8'd0;
                end else if (bus.req_1) begin
                    state_d = GRANT;
                    own_d   = 1'b1;
                    op_d    = bus.op_1;
                    hold_d  = 8'd0;
                end
            end

            GRANT: begin
                if (owner_done || !owner_req || (hold_q == HOLD_LAST)) begin
                    state_d = RELEASE;
                    own_d   = 1'b0;
                    op_d    = '0;
                    hold_d  = 8'd0;
                    prio_d  = ~own_q;
                    tout_d  = !owner_done && owner_req;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end

            RELEASE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                own_d   = 1'b0;
                op_d    = '0;
                hold_d  = 8'd0;
            end
        endcase
    end

    // State and registered outputs; grants and bus_valid are decoded from the
    // next state so they appear in the same cycle the state is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            own_q     <= 1'b0;
            op_q      <= '0;
            hold_q    <= 8'd0;
            prio_q    <= 1'b0;
            tout_q    <= 1'b0;
            grant_0_q <= 1'b0;
            grant_1_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            op_q      <= op_d;
            hold_q    <= hold_d;
            prio_q    <= prio_d;
            tout_q    <= tout_d;
            grant_0_q <= (state_d == GRANT) && !own_d;
            grant_1_q <= (state_d == GRANT) && own_d;
            valid_q   <= (state_d == GRANT);
        end
    end

    assign bus.grant_0     = grant_0_q;
    assign bus.grant_1     = grant_1_q;
    assign bus.owner       = own_q;
    assign bus.bus_valid   = valid_q;
    assign bus.bus_op      = op_q;
    assign bus.timeout_err = tout_q;

`ifdef BUS_ARB_STATS_EN
    logic [15:0] cnt_0_q;
    logic [15:0] cnt_1_q;

    // Saturating count of done-terminated grants; abandons and timeouts skip.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_0_q <= 16'h0000;
            cnt_1_q <= 16'h0000;
        end else if ((state_q == GRANT) && owner_done) begin
            if (!own_q) begin
                if (cnt_0_q != 16'hFFFF) begin
                    cnt_0_q <= cnt_0_q + 16'd1;
                end
            end else begin
                if (cnt_1_q != 16'hFFFF) begin
                    cnt_1_q <= cnt_1_q + 16'd1;
                end
            end
        end
    end

    assign bus.xact_cnt_0 = cnt_0_q;
    assign bus.xact_cnt_1 = cnt_1_q;
`else
    assign bus.xact_cnt_0 = 16'h0000;
    assign bus.xact_cnt_1 = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// transactions, all checked against a transaction-level model of the rules
// (who wins, how long the grant lasts, whether it times out or counts).
module tb_bus_arbiter;

    localparam int OPW      = 3;
    localparam int MAX_HOLD = 8;

    localparam int END_DONE    = 0;
    localparam int END_ABANDON = 1;
    localparam int END_NONE    = 2;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;

    int exp_ptr  = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.OPW(OPW)) bus ();

    bus_arbiter #(
        .OPW      (OPW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OPW+4:0] observed();
        return {bus.grant_0, bus.grant_1, bus.owner, bus.bus_valid, bus.bus_op, bus.timeout_err};
    endfunction

    function automatic void model_count(input int w);
`ifdef BUS_ARB_STATS_EN
        if (w == 0) begin
            if (exp_cnt0 < 65535) exp_cnt0++;
        end else begin
            if (exp_cnt1 < 65535) exp_cnt1++;
        end
`else
        if (w > 1) $display("[TB] note: unexpected cpu index %0d", w);
`endif
    endfunction

    // One arbitration round starting in an IDLE cycle: request, grant window,
    // RELEASE cycle, and the IDLE cycle that follows it.
    task automatic run_xact(input int r0, input int r1,
                            input logic [OPW-1:0] o0, input logic [OPW-1:0] o1,
                            input int kind, input int e, input string tag);
        int             w;
        int             len;
        logic           wb;
        logic           timed;
        logic [OPW-1:0] exp_op;
        logic [OPW+4:0] exp;
        logic [OPW+4:0] obs;

        bus.req_0  = logic'(r0 != 0);
        bus.req_1  = logic'(r1 != 0);
        bus.op_0   = o0;
        bus.op_1   = o1;
        bus.done_0 = 1'b0;
        bus.done_1 = 1'b0;

        w      = (r0 != 0 && r1 != 0) ? exp_ptr : ((r1 != 0) ? 1 : 0);
        wb     = (w == 1);
        exp_op = wb ? o1 : o0;
        if (kind == END_NONE) begin
            len   = MAX_HOLD;
            timed = 1'b1;
        end else begin
            len   = e;
            timed = 1'b0;
        end

        for (int k = 1; k <= len; k++) begin
            tick();
            exp = {~wb, wb, wb, 1'b1, exp_op, 1'b0};
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL %s grant cycle %0d: got %b, expected %b", tag, k, obs, exp);
            end
            bus.op_0 = OPW'($urandom);
            bus.op_1 = OPW'($urandom);
            if (wb) begin
                bus.done_0 = logic'(k % 2);
                bus.done_1 = (k == len) && (kind == END_DONE);
                if ((k == len) && (kind == END_ABANDON)) bus.req_1 = 1'b0;
            end else begin
                bus.done_1 = logic'(k % 2);
                bus.done_0 = (k == len) && (kind == END_DONE);
                if ((k == len) && (kind == END_ABANDON)) bus.req_0 = 1'b0;
            end
        end

        tick();
        bus.done_0 = 1'b0;
        bus.done_1 = 1'b0;
        if (wb) bus.req_1 = 1'b0;
        else    bus.req_0 = 1'b0;
        if (kind == END_DONE) model_count(w);
        exp_ptr = 1 - w;

        exp = {{(OPW+4){1'b0}}, timed};
        obs = observed();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s release: got %b, expected %b", tag, obs, exp);
        end
        checks++;
        if ({bus.xact_cnt_0, bus.xact_cnt_1} !== {16'(exp_cnt0), 16'(exp_cnt1)}) begin
            errors++;
            $display("[TB] FAIL %s counters: got %0d/%0d, expected %0d/%0d",
                     tag, bus.xact_cnt_0, bus.xact_cnt_1, exp_cnt0, exp_cnt1);
        end

        tick();
        obs = observed();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL %s idle after release: got %b, expected 0", tag, obs);
        end
    endtask

    task automatic test_reset();
        logic [OPW+4:0] obs;
        rst        = 1'b1;
        bus.req_0  = 1'b0;
        bus.req_1  = 1'b0;
        bus.op_0   = '0;
        bus.op_1   = '0;
        bus.done_0 = 1'b0;
        bus.done_1 = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        exp_ptr  = 0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        for (int c = 0; c < 10; c++) begin
            obs = observed();
            checks++;
            if (obs !== '0 || bus.xact_cnt_0 !== 16'h0 || bus.xact_cnt_1 !== 16'h0) begin
                errors++;
                $display("[TB] FAIL reset idle cycle %0d: got %b cnt %0d/%0d, expected all 0",
                         c, obs, bus.xact_cnt_0, bus.xact_cnt_1);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) begin
            run_xact(1, 1, OPW'($urandom), OPW'($urandom), END_DONE, 2, "round_robin");
        end
    endtask

    task automatic test_single_request();
        run_xact(1, 0, 3'd1, 3'd0, END_DONE, 3, "single_request");
    endtask

    task automatic test_timeout();
        run_xact(0, 1, 3'd2, 3'd6, END_NONE, 0, "timeout");
    endtask

    task automatic test_done_timeout_tie();
        run_xact(0, 1, 3'd0, 3'd7, END_DONE, MAX_HOLD, "done_timeout_tie");
    endtask

    task automatic test_reset_mid_grant();
        logic [OPW+4:0] obs;
        run_xact(1, 0, 3'd3, 3'd0, END_DONE, 1, "pre_reset");
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b1;
        bus.op_1  = 3'd5;
        tick();
        tick();
        obs = observed();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mid_grant before reset: got %b, expected 01111010", obs);
        end
        rst        = 1'b1;
        bus.done_1 = 1'b1;
        tick();
        exp_ptr  = 0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        obs = observed();
        checks++;
        if (obs !== '0 || bus.xact_cnt_0 !== 16'h0 || bus.xact_cnt_1 !== 16'h0) begin
            errors++;
            $display("[TB] FAIL mid_grant reset: got %b cnt %0d/%0d, expected all 0",
                     obs, bus.xact_cnt_0, bus.xact_cnt_1);
        end
        rst        = 1'b0;
        bus.done_1 = 1'b0;
        run_xact(1, 1, 3'd4, 3'd2, END_DONE, 2, "post_reset_priority");
    endtask

    task automatic test_random();
        int             pattern;
        int             kind;
        int             e;
        logic [OPW+4:0] obs;
        for (int i = 0; i < 40; i++) begin
            pattern = int'($urandom_range(0, 3));
            if (pattern == 0) begin
                bus.req_0 = 1'b0;
                bus.req_1 = 1'b0;
                tick();
                obs = observed();
                checks++;
                if (obs !== '0) begin
                    errors++;
                    $display("[TB] FAIL random idle %0d: got %b, expected 0", i, obs);
                end
            end else begin
                kind = int'($urandom_range(0, 2));
                if (kind == END_DONE)         e = int'($urandom_range(1, MAX_HOLD));
                else if (kind == END_ABANDON) e = int'($urandom_range(1, MAX_HOLD - 1));
                else                          e = 0;
                run_xact((pattern != 2) ? 1 : 0, (pattern != 1) ? 1 : 0,
                         OPW'($urandom), OPW'($urandom), kind, e, "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_request();
        test_timeout();
        test_done_timeout_tie();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
